// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  // Number of decimal digits needed to show the largest w-bit unsigned value.
  function automatic int min_digits(input int w);
    int v;
    int d;
    v = (1 << w) - 1;
    d = 1;
    for (int i = 0; i < 8; i++) begin
      if (v >= 10) begin
        v = v / 10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle of bin2bcd_seq; blank exists only with BIN2BCD_BLANK_EN.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
);

  logic                     in_valid;
  logic                     in_ready;
  logic [W-1:0]             bin_in;
  logic [BCD_DIGIT_W*D-1:0] bcd;
  logic                     done;
`ifdef BIN2BCD_BLANK_EN
  logic [D-1:0]             blank;
`endif

  modport master (
    output in_valid,
    output bin_in,
    input  in_ready,
    input  bcd,
`ifdef BIN2BCD_BLANK_EN
    input  blank,
`endif
    input  done
  );

  modport slave (
    input  in_valid,
    input  bin_in,
    output in_ready,
    output bcd,
`ifdef BIN2BCD_BLANK_EN
    output blank,
`endif
    output done
  );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_adj3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: W shift cycles plus one load cycle per value.
// Optional leading-zero mask output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * D;
  localparam int SW    = BCD_W + W;
  localparam int CNT_W = $clog2(W + 1);

  if (W < 1 || W > 16 || D < min_digits(W)) begin : g_bad_params
    $error("bin2bcd_seq: W=%0d needs at least %0d digits, D=%0d", W, min_digits(W), D);
  end

  state_e            r_state;
  logic [SW-1:0]     r_scratch;
  logic [CNT_W-1:0]  r_cnt;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_done;
  logic [SW-1:0]     w_adj;

  // Correct every scratch digit before the shift moves it up one bit.
  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_digit (r_scratch[W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .o_digit (w_adj[W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end
  assign w_adj[W-1:0] = r_scratch[W-1:0];

`ifdef BIN2BCD_BLANK_EN
  localparam logic [D-1:0] BLANK_RST = {D{1'b1}} << 1;

  logic [D-1:0] r_blank;
  logic [D-1:0] w_blank;
  logic         w_nz_above;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_blank    = '0;
    w_nz_above = 1'b0;
    for (int i = D - 1; i >= 1; i--) begin
      w_nz_above = w_nz_above | (r_scratch[W + BCD_DIGIT_W*i +: BCD_DIGIT_W] != 4'd0);
      w_blank[i] = ~w_nz_above;
    end
  end

  assign bus.blank = r_blank;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      r_blank   <= BLANK_RST;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_scratch <= {{BCD_W{1'b0}}, bus.bin_in};
            r_cnt     <= CNT_W'(W);
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_adj << 1;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_bcd   <= r_scratch[SW-1 -: BCD_W];
          r_done  <= 1'b1;
`ifdef BIN2BCD_BLANK_EN
          r_blank <= w_blank;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.bcd      = r_bcd;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and exhaustive self-checking bench for bin2bcd_seq at W=8, D=3.
module tb_bin2bcd_seq;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int BW = 4 * D;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin2bcd_seq_if #(.W(W), .D(D)) bus ();

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] model_bcd(input int v);
    logic [BW-1:0] r;
    int n;
    n = v;
    r = '0;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] model_blank(input int v);
    return {v < 100, v < 10, 1'b0};
  endfunction

  // Runs one conversion starting at posedge+1; returns latency, result and observations.
  task automatic convert(input logic [W-1:0] v, output int lat, output logic [BW-1:0] res,
                         output bit got, output int rlow, output bit changed);
    int guard;
    logic [BW-1:0] held;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bin_in   = ~v;
    held    = bus.bcd;
    rlow    = bus.in_ready ? 0 : 1;
    changed = 1'b0;
    got     = 1'b0;
    lat     = 0;
    res     = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) begin
        got = 1'b1;
        res = bus.bcd;
      end else begin
        if (bus.bcd !== held) changed = 1'b1;
        if (!bus.in_ready) rlow++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout: value=%0d no done within 40 cycles", v);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", bus.in_ready); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b exp 0", bus.done); end
    checks++;
    if (bus.bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd: got %h exp 000", bus.bcd); end
`ifdef BIN2BCD_BLANK_EN
    checks++;
    if (bus.blank !== 3'b110) begin failures++; $display("FAIL reset_blank: got %b exp 110", bus.blank); end
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    int lat, rlow;
    logic [BW-1:0] res;
    bit got, changed;
    convert(8'd255, lat, res, got, rlow, changed);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL max_latency: got %0d exp 9", lat); end
    checks++;
    if (res !== 12'h255) begin failures++; $display("FAIL max_bcd: got %h exp 255", res); end
`ifdef BIN2BCD_BLANK_EN
    checks++;
    if (bus.blank !== 3'b000) begin failures++; $display("FAIL max_blank: got %b exp 000", bus.blank); end
`endif
    checks++;
    if (rlow !== 9) begin failures++; $display("FAIL max_ready_low: got %0d exp 9", rlow); end
    checks++;
    if (changed !== 1'b0) begin failures++; $display("FAIL max_bcd_stable: bcd moved before done"); end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL max_done_pulse: got %b exp 0", bus.done); end
    checks++;
    if (bus.bcd !== 12'h255) begin failures++; $display("FAIL max_bcd_hold: got %h exp 255", bus.bcd); end
  endtask

  task automatic test_small_values();
    logic [W-1:0]  vals  [3] = '{8'd0, 8'd7, 8'd100};
    logic [BW-1:0] exps  [3] = '{12'h000, 12'h007, 12'h100};
    logic [D-1:0]  blnks [3] = '{3'b110, 3'b110, 3'b000};
    int lat, rlow;
    logic [BW-1:0] res;
    bit got, changed;
    for (int i = 0; i < 3; i++) begin
      convert(vals[i], lat, res, got, rlow, changed);
      checks++;
      if (res !== exps[i]) begin failures++; $display("FAIL small_bcd[%0d]: got %h exp %h", vals[i], res, exps[i]); end
`ifdef BIN2BCD_BLANK_EN
      checks++;
      if (bus.blank !== blnks[i]) begin failures++; $display("FAIL small_blank[%0d]: got %b exp %b", vals[i], bus.blank, blnks[i]); end
`else
      if (blnks[i] === 3'bxxx) $display("unreachable");
`endif
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    logic [BW-1:0] res [2];
    int acc_n, res_n;
    bit rb;
    acc_n = 0;
    res_n = 0;
    acc   = '{0, 0};
    res   = '{'0, '0};
    bus.bin_in   = 8'd42;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && res_n < 2; cyc++) begin
      rb = bus.in_ready;
      @(posedge clk); #1;
      if (rb && bus.in_valid && acc_n < 2) begin
        acc[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) bus.bin_in = 8'd77;
        else            bus.in_valid = 1'b0;
      end
      if (bus.done && res_n < 2) begin
        res[res_n] = bus.bcd;
        res_n++;
      end
      if (acc_n == 1 && cyc == acc[0] + 5) bus.bin_in = 8'd199;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc_n !== 2 || res_n !== 2) begin
      failures++; $display("FAIL b2b_count: accepts=%0d results=%0d exp 2/2", acc_n, res_n);
    end
    checks++;
    if (acc[1] - acc[0] !== 10) begin failures++; $display("FAIL b2b_spacing: got %0d exp 10", acc[1] - acc[0]); end
    checks++;
    if (res[0] !== 12'h042) begin failures++; $display("FAIL b2b_first: got %h exp 042", res[0]); end
    checks++;
    if (res[1] !== 12'h199) begin failures++; $display("FAIL b2b_second: got %h exp 199", res[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat, rlow;
    logic [BW-1:0] res;
    bit got, changed, seen_done;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    bus.bin_in   = 8'd123;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.bcd !== 12'h000) begin failures++; $display("FAIL abort_bcd: got %h exp 000", bus.bcd); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b exp 1", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: done seen after aborted conversion"); end
    checks++;
    if (bus.bcd !== 12'h000 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_idle: bcd=%h ready=%b exp 000/1", bus.bcd, bus.in_ready);
    end
    convert(8'd58, lat, res, got, rlow, changed);
    checks++;
    if (res !== 12'h058) begin failures++; $display("FAIL abort_next: got %h exp 058", res); end
  endtask

  task automatic test_exhaustive();
    int lat, rlow;
    logic [BW-1:0] res;
    bit got, changed;
    for (int v = 0; v < 256; v++) begin
      convert(W'(v), lat, res, got, rlow, changed);
      checks++;
      if (res !== model_bcd(v)) begin failures++; $display("FAIL exh_bcd[%0d]: got %h exp %h", v, res, model_bcd(v)); end
      checks++;
      if (lat !== W + 1 || rlow !== W + 1) begin
        failures++; $display("FAIL exh_timing[%0d]: latency=%0d ready_low=%0d exp %0d", v, lat, rlow, W + 1);
      end
      checks++;
      if (changed !== 1'b0) begin failures++; $display("FAIL exh_stable[%0d]: bcd moved before done", v); end
`ifdef BIN2BCD_BLANK_EN
      checks++;
      if (bus.blank !== model_blank(v)) begin
        failures++; $display("FAIL exh_blank[%0d]: got %b exp %b", v, bus.blank, model_blank(v));
      end
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_max();
    test_small_values();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
